mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_if.sv | 19 +
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the register-file read stage and the mul/div unit.
interface mul_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_we;
  logic            lo_we;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, a, b, hi_we, lo_we,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU, one bit per cycle, results in HI/LO.
// Magnitudes are iterated unsigned; signs are applied in the FIX state.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rstd,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              dz_q, dz_d;

  logic              accept, req_sgn, req_dz;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN+1:0]   rem_diff;
  logic              div_ok;
  logic              fix_sgn;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign accept  = (state_q == S_IDLE) && bus.start;
  assign req_sgn = ~bus.op[0];
  assign req_dz  = bus.op[1] && (bus.b == '0);
  assign abs_a   = (req_sgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign abs_b   = (req_sgn && bus.b[XLEN-1]) ? -bus.b : bus.b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  // Divide: acc[XLEN-1:0] shifts dividend bits out and quotient bits in.
  assign rem_sh   = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, opb_q};
  assign div_ok   = ~rem_diff[XLEN+1];

  assign fix_sgn  = ~op_q[0];
  assign prod_fix = (fix_sgn && (sa_q ^ sb_q)) ? -acc_q : acc_q;
  assign quot_fix = (fix_sgn && (sa_q ^ sb_q)) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = (fix_sgn && sa_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  // State register
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; divide-by-zero skips the iterations but still passes FIX
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = req_dz ? S_FIX : S_RUN;
      S_RUN:  if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.div_zero = dz_q;
    bus.hi       = hi_q;
    bus.lo       = lo_q;
  end

  // Datapath next-values
  always_comb begin
    cnt_d = (state_q == S_RUN) ? cnt_q + CW'(1) : '0;
    op_d  = op_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    opb_d = opb_q;
    acc_d = acc_q;
    rem_d = rem_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dz_d  = dz_q;
    if (accept) begin
      op_d  = bus.op;
      sa_d  = bus.a[XLEN-1];
      sb_d  = bus.b[XLEN-1];
      opb_d = abs_b;
      acc_d = {{XLEN{1'b0}}, abs_a};
      rem_d = '0;
      dz_d  = req_dz;
    end else if (state_q == S_RUN) begin
      if (op_q[1]) begin
        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ok};
        rem_d = div_ok ? rem_diff[XLEN:0] : rem_sh;
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end else if (state_q == S_FIX && !dz_q) begin
      if (op_q[1]) begin
        lo_d = quot_fix;
        hi_d = rem_fix;
      end else begin
        hi_d = prod_fix[2*XLEN-1:XLEN];
        lo_d = prod_fix[XLEN-1:0];
      end
    end
    // mthi/mtlo only when idle and no operation is being accepted
    if (state_q == S_IDLE && !bus.start) begin
      if (bus.hi_we) hi_d = bus.a;
      if (bus.lo_we) lo_d = bus.a;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      cnt_q <= '0;
      op_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      opb_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      opb_q <= opb_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dz_q  <= dz_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; hand-computed HI/LO/timing expectations.
module tb_mul_div_unit;
  logic clk;
  logic rstd;
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then watch 40 cycles. done_at = edge index of first done
  // sample (accepting edge = 0); hazard injects ignored start and hi_we.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hazard, input bit with_lo_we,
                       output int done_at, output int npulse, output int nbusy);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.lo_we = with_lo_we;
    tick();
    bus.start = 1'b0; bus.lo_we = 1'b0;
    done_at = -1; npulse = 0; nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin
        if (done_at < 0) done_at = k;
        npulse++;
      end
      if (bus.busy) nbusy++;
      if (hazard && k == 5) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1; bus.b = 32'd1;
      end else if (hazard && k == 8) begin
        bus.start = 1'b0; bus.hi_we = 1'b1; bus.a = 32'hAAAAAAAA;
      end else begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      tick();
    end
  endtask

  int done_at, npulse, nbusy;

  initial begin
    rstd = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    #12;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_dz",   {63'd0, bus.div_zero}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rstd = 1'b1;
    tick();

    // 1: MULTU max*max with latency checks
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("multu_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    check("multu_done_at", 64'(done_at), 64'd33);
    check("multu_npulse", 64'(npulse), 64'd1);
    check("multu_nbusy", 64'(nbusy), 64'd34);

    // 2: MULT -3 * 7
    do_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("mult_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);

    // 3: divides
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("div_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    check("div_done_at", 64'(done_at), 64'd33);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("divu", {bus.hi, bus.lo}, {32'd2, 32'd14});
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);
    check("div_ovf_dz", {63'd0, bus.div_zero}, 64'd0);

    // 4: mthi/mtlo then divide by zero
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.a = 32'h5A5A5A5A;
    tick();
    check("mt_both", {bus.hi, bus.lo}, 64'h5A5A5A5A_5A5A5A5A);
    bus.lo_we = 1'b0; bus.a = 32'h11111111;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.a = 32'h22222222;
    tick();
    bus.lo_we = 1'b0;
    check("preload", {bus.hi, bus.lo}, 64'h11111111_22222222);
    do_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("dz_done_at", 64'(done_at), 64'd1);
    check("dz_npulse", 64'(npulse), 64'd1);
    check("dz_flag", {63'd0, bus.div_zero}, 64'd1);
    check("dz_hilo", {bus.hi, bus.lo}, 64'h11111111_22222222);
    do_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("dz_clear", {63'd0, bus.div_zero}, 64'd0);
    check("multu_small", {bus.hi, bus.lo}, {32'd0, 32'd6});

    // 5: hazards during RUN, then start beats lo_we
    do_op(2'b00, 32'd6, 32'hFFFFFFF9, 1'b1, 1'b0, done_at, npulse, nbusy);
    check("haz_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFD6);
    check("haz_npulse", 64'(npulse), 64'd1);
    do_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b1, done_at, npulse, nbusy);
    check("start_wins", {bus.hi, bus.lo}, {32'd0, 32'd15});

    // 6: reset in the middle of a DIVU
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    #2 rstd = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    npulse = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done) npulse++;
    end
    #2 rstd = 1'b1;
    tick();
    for (int k = 0; k < 30; k++) begin
      if (bus.done || bus.busy) npulse++;
      tick();
    end
    check("mid_rst_nodone", 64'(npulse), 64'd0);
    do_op(2'b01, 32'd4, 32'd5, 1'b0, 1'b0, done_at, npulse, nbusy);
    check("post_rst_mul", {bus.hi, bus.lo}, {32'd0, 32'd20});
    check("post_rst_done_at", 64'(done_at), 64'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
